// File: rtl/rom_stream_rd_pkg.sv
// Shared types and constants for the ROM stream reader.
package rom_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W      = FIFO_CW + 1;

endpackage

// File: rtl/rom_stream_rd_fifo_sync.sv
// Small synchronous FIFO with occupancy count; head word is presented on data_o.
module fifo_sync #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  // Push may proceed when full only if the head leaves in the same cycle.
  always_comb begin
    do_pop_s  = pop_i && (count_q != CW'(0));
    do_push_s = push_i && ((count_q != CW'(DEPTH)) || do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_q    <= '{default: {WIDTH{1'b0}}};
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == CW'(0));

endmodule

// File: rtl/rom_stream_rd.sv
// Burst read sequencer in front of a single-port ROM, streaming words out
// through a small FIFO so the consumer may stall without losing ROM data.
module rom_stream_rd
  import rom_stream_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 8,
  parameter  int OUT_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [AW-1:0]    base_addr_i,
  input  logic [LW-1:0]    len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rom_rd_en_o,
  output logic [AW-1:0]    rom_rd_addr_o,
  input  logic [WIDTH-1:0] rom_rd_data_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  state_e             state_q, state_d;
  logic [AW-1:0]      next_addr_q, next_addr_d;
  logic [AW-1:0]      last_addr_q, last_addr_d;
  logic [LW-1:0]      issue_left_q, issue_left_d;
  logic [LW-1:0]      out_left_q, out_left_d;
  logic [FIFO_CW-1:0] fifo_count_s;
  logic               fifo_empty_s;
  logic               pop_s, push_s, rd_en_s, inflight_s;
  logic [OCC_W-1:0]   occupancy_s;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? {AW{1'b0}} : a + AW'(1);
  endfunction

  assign pop_s       = !fifo_empty_s && out_ready_i;
  // Slots committed after this cycle: buffered words plus reads still in the ROM.
  assign occupancy_s = {1'b0, fifo_count_s} + {{FIFO_CW{1'b0}}, inflight_s}
                     - {{FIFO_CW{1'b0}}, pop_s};

  // Next-state, read issue and burst bookkeeping.
  always_comb begin
    state_d      = state_q;
    next_addr_d  = next_addr_q;
    last_addr_d  = last_addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    rd_en_s      = 1'b0;
    if (pop_s && (out_left_q != LW'(0))) begin
      out_left_d = out_left_q - LW'(1);
    end else begin
      out_left_d = out_left_q;
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != LW'(0)) begin
            next_addr_d  = base_addr_i;
            issue_left_d = len_i;
            out_left_d   = len_i;
            state_d      = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if ((issue_left_q != LW'(0)) && (occupancy_s < OCC_W'(FIFO_DEPTH))) begin
          rd_en_s      = 1'b1;
          last_addr_d  = next_addr_q;
          next_addr_d  = addr_inc(next_addr_q);
          issue_left_d = issue_left_q - LW'(1);
          if (issue_left_q == LW'(1)) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && (out_left_q == LW'(1))) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      next_addr_q  <= {AW{1'b0}};
      last_addr_q  <= {AW{1'b0}};
      issue_left_q <= {LW{1'b0}};
      out_left_q   <= {LW{1'b0}};
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      last_addr_q  <= last_addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
    end
  end

  if (OUT_REG != 0) begin : g_reg_rom
    logic inflight_q, inflight_d;
    assign inflight_d = rd_en_s;
    // Marks the cycle in which registered ROM data becomes valid.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= inflight_d;
      end
    end
    assign inflight_s = inflight_q;
    assign push_s     = inflight_q;
  end else begin : g_comb_rom
    assign inflight_s = 1'b0;
    assign push_s     = rd_en_s;
  end

  fifo_sync #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_s),
    .data_i  (rom_rd_data_i),
    .pop_i   (pop_s),
    .data_o  (out_data_o),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s)
  );

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign rom_rd_en_o   = rd_en_s;
  assign rom_rd_addr_o = rd_en_s ? next_addr_q : last_addr_q;
  assign out_valid_o   = !fifo_empty_s;

endmodule

// File: doc/rom_stream_rd.md
Name: rom_stream_rd

Overview:
- Read sequencer that sits directly in front of a single-port ROM.
- Drives the ROM's read enable and address, and absorbs the ROM's 0- or 1-cycle read latency.
- Presents a burst of ROM words as a valid/ready stream to downstream logic.
- Used for coefficient, table and microcode playback where the consumer may stall.

Parameters:
- WIDTH, 8, data word width; must match the attached ROM.
- DEPTH, 8, ROM depth in words; address width is $clog2(DEPTH).
- OUT_REG, 1, ROM read latency: 1 = registered ROM output, 0 = combinational.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  start a burst; sampled only when idle
- base_addr_i  in  $clog2(DEPTH)  first ROM address of the burst; sampled with start_i
- len_i  in  $clog2(DEPTH+1)  number of words, 0..DEPTH; sampled with start_i
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse when the last word is accepted downstream
- rom_rd_en_o  out  1  ROM read enable
- rom_rd_addr_o  out  $clog2(DEPTH)  ROM read address
- rom_rd_data_i  in  WIDTH  ROM read data
- out_data_o  out  WIDTH  stream data
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: busy_o=0, done_o=0, rom_rd_en_o=0, rom_rd_addr_o=0, out_valid_o=0, out_data_o=0; FSM in IDLE; FIFO empty; in-flight tracker cleared.
- FSM states:
  - IDLE: start_i=1 with len_i>0 latches address and count, goes to RUN.
  - IDLE: start_i=1 with len_i=0 goes to DONE, no ROM access.
  - RUN: issues reads; after the last read is issued, goes to DRAIN.
  - DRAIN: waits until the last word is accepted, then goes to DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in RUN, DRAIN and DONE.
- start_i is ignored in any state other than IDLE, including the DONE cycle.
- Output buffer: internal 4-entry FIFO. out_valid_o = FIFO non-empty; out_data_o = FIFO head.
- Transfer rule: a transfer occurs when out_valid_o & out_ready_i.
- out_data_o is stable while out_valid_o=1 and out_ready_i=0.
- Issue rule, in RUN: rom_rd_en_o=1 when (FIFO count + reads in flight − pop this cycle) < 4 and words remain to issue.
- Flow control: the FIFO never overflows; there is no backpressure path into the ROM.
- Address sequence: starts at base_addr_i, increments by 1 per issued read, wraps from DEPTH−1 to 0 (modulo DEPTH; DEPTH need not be a power of two).
- Latency, OUT_REG=1 (start_i high in cycle 0):
  - First rom_rd_en_o in cycle 1.
  - ROM data captured into the FIFO at the end of cycle 2.
  - First out_valid_o in cycle 3.
- Latency, OUT_REG=0: capture at the end of the issue cycle; first out_valid_o in cycle 2.
- In-flight tracking: a 1-bit pipeline with OUT_REG stages marks which cycles carry valid ROM data. rom_rd_data_i is captured only when that bit is set.
- Throughput: with out_ready_i held at 1, one word per cycle sustained and no bubbles after the first word.
- rom_rd_addr_o holds its last value when rom_rd_en_o=0.
- Burst length and done:
  - done_o asserts in the cycle after the transfer of word len.
  - busy_o falls in the cycle after done_o.
- A full wrap (len=DEPTH) reads every address exactly once.
- Reset mid-burst: immediate return to reset values. FIFO contents and pending reads are discarded, and no done_o pulse is produced.

Decomposition:
- Package rom_stream_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - localparam FIFO_DEPTH=4
- Sub-module fifo_sync: 4-entry synchronous FIFO with count output, same clock and reset. It may be reused elsewhere.

Test Plan:
- Basic burst: DEPTH=8, ROM[i]=i+0x10, OUT_REG=1; start base=2 len=4, ready=1 → out 0x12,0x13,0x14,0x15 in consecutive cycles starting cycle 3; done_o pulse one cycle after 0x15; busy_o low the cycle after.
- Wrap: base=6 len=4 → addresses 6,7,0,1; data 0x16,0x17,0x10,0x11.
- Backpressure: len=8, ready toggled randomly; also held low for 10 cycles mid-burst → all 8 words in order, none duplicated or dropped; out_data_o stable while stalled; ROM reads stop when FIFO plus in-flight reads reach 4.
- Zero length and ignored start: len=0 → done_o pulse in cycle 1, rom_rd_en_o never asserted; start_i pulsed during RUN → no effect on the address sequence.
- OUT_REG=0 variant: base=0 len=8 → first valid in cycle 2, 8 words back-to-back.
- Reset mid-burst: assert rst_n_i=0 after 3 words → outputs return to reset values asynchronously; a new burst after release streams correctly from its own base.
